// File: rtl/dot_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_scan_ctrl
// Function : 5x7 LED dot-matrix column scanner with double-buffered frame
//            store; host commits swap banks only at a frame boundary.
// Revision : 1.0
// ============================================================================
module dot_matrix_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 5400000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_col,
    input  logic [6:0] wr_data,
    input  logic       wr_commit,
    output logic       commit_pending,
    output logic       frame_tick,
    output logic [1:0] portA,
    output logic [1:0] portB,
    output logic [6:0] row,
    output logic [4:0] col
);

    localparam logic [31:0] C_LAST_CNT  = 32'(SCAN_DIV - 1);
    localparam logic [31:0] C_BLANK_CYC = 32'(BLANK_CYC);
    localparam logic [2:0]  C_LAST_COL  = 3'd4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic        r_sel;
    logic [6:0]  r_bank [0:1][0:4];
    logic        r_pending;
    logic        r_ready;
    logic        r_tick;
    logic [1:0]  r_port;
    logic [6:0]  r_row;
    logic [4:0]  r_col;

    logic        w_wrap;
    logic        w_swap;
    logic [31:0] w_cnt_nxt;
    logic [2:0]  w_idx_nxt;
    logic        w_sel_nxt;
    logic        w_pending_nxt;
    logic        w_write;
    state_t      w_state_nxt;

    always_comb begin
        w_wrap        = (r_cnt == C_LAST_CNT);
        w_swap        = w_wrap && (r_idx == C_LAST_COL) && r_pending;
        w_cnt_nxt     = w_wrap ? 32'd0 : r_cnt + 32'd1;
        w_idx_nxt     = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == C_LAST_COL) ? 3'd0 : r_idx + 3'd1;
        end
        w_sel_nxt     = r_sel ^ w_swap;
        // A commit arriving while one is pending is dropped; a swap retires it.
        w_pending_nxt = r_pending ? !w_swap : wr_commit;
        w_write       = wr_valid && r_ready && (wr_col <= C_LAST_COL);
        w_state_nxt   = (w_cnt_nxt < C_BLANK_CYC) ? ST_BLANK : ST_SHOW;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 32'd0;
            r_idx     <= 3'd0;
            r_sel     <= 1'b0;
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
            r_tick    <= 1'b0;
            r_port    <= 2'b00;
            r_row     <= 7'd0;
            r_col     <= 5'b11111;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 5; c++) begin
                    r_bank[b][c] <= 7'd0;
                end
            end
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_sel     <= w_sel_nxt;
            r_pending <= w_pending_nxt;
            r_ready   <= !w_pending_nxt;
            r_tick    <= (w_cnt_nxt == C_LAST_CNT) && (w_idx_nxt == C_LAST_COL);
            r_port    <= 2'b01;
            // Writes go to the bank not on display; no swap can coincide with one.
            if (w_write) begin
                r_bank[~r_sel][wr_col] <= wr_data;
            end
            case (w_state_nxt)
                ST_SHOW: begin
                    r_col <= ~(5'd1 << w_idx_nxt);
                    r_row <= r_bank[w_sel_nxt][w_idx_nxt];
                end
                default: begin
                    r_col <= 5'b11111;
                    r_row <= 7'd0;
                end
            endcase
        end
    end

    assign wr_ready       = r_ready;
    assign commit_pending = r_pending;
    assign frame_tick     = r_tick;
    assign portA          = r_port;
    assign portB          = r_port;
    assign row            = r_row;
    assign col            = r_col;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_matrix_scan_ctrl
// Function : Self-checking bench for dot_matrix_scan_ctrl (SCAN_DIV=8,
//            BLANK_CYC=2) using a cycle model, scoreboard and vector table.
// Revision : 1.0
// ============================================================================
module tb_dot_matrix_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_col = 3'd0;
    logic [6:0] wr_data = 7'd0;
    logic       wr_commit = 1'b0;
    logic       wr_ready;
    logic       commit_pending;
    logic       frame_tick;
    logic [1:0] portA;
    logic [1:0] portB;
    logic [6:0] row;
    logic [4:0] col;

    dot_matrix_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_col        (wr_col),
        .wr_data       (wr_data),
        .wr_commit     (wr_commit),
        .commit_pending(commit_pending),
        .frame_tick    (frame_tick),
        .portA         (portA),
        .portB         (portB),
        .row           (row),
        .col           (col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] port_a;
        logic [1:0] port_b;
        logic [4:0] col;
        logic [6:0] row;
        logic       tick;
        logic       ready;
        logic       pend;
    } out_t;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [6:0] d;
        logic       cm;
        logic       exp_pend;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    out_t sb_q[$];
    vec_t tbl[12];

    int         m_cnt;
    int         m_idx;
    logic       m_pend;
    logic       m_ready;
    logic [6:0] m_front [5];
    logic [6:0] m_back  [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        return out_t'({portA, portB, col, row, frame_tick, wr_ready, commit_pending});
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_idx   = 0;
        m_pend  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_front[i] = 7'd0;
            m_back[i]  = 7'd0;
        end
    endtask

    task automatic model_edge(input logic v, input logic [2:0] c, input logic [6:0] d, input logic cm);
        logic [6:0] tmp [5];
        logic [4:0] oh;
        out_t       e;
        if (v && m_ready && c < 5) m_back[c] = d;
        if (m_cnt == SD - 1 && m_idx == 4 && m_pend) begin
            tmp     = m_front;
            m_front = m_back;
            m_back  = tmp;
            m_pend  = 1'b0;
        end else if (!m_pend && cm) begin
            m_pend = 1'b1;
        end
        if (m_cnt == SD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 5;
        end else begin
            m_cnt++;
        end
        m_ready  = !m_pend;
        oh       = 5'd1 << m_idx;
        e.port_a = 2'b01;
        e.port_b = 2'b01;
        e.col    = (m_cnt < BC) ? 5'b11111 : ~oh;
        e.row    = (m_cnt < BC) ? 7'd0 : m_front[m_idx];
        e.tick   = (m_cnt == SD - 1) && (m_idx == 4);
        e.ready  = m_ready;
        e.pend   = m_pend;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic [6:0] d, input logic cm);
        out_t e;
        wr_valid  = v;
        wr_col    = c;
        wr_data   = d;
        wr_commit = cm;
        @(posedge clk);
        model_edge(v, c, d, cm);
        #1;
        if (sb_q.size() == 0) begin
            check($sformatf("scoreboard empty at cycle %0d", cyc), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("cycle %0d outputs", cyc), 32'(dut_out()), 32'(e));
        end
        cyc++;
        wr_valid  = 1'b0;
        wr_col    = 3'd0;
        wr_data   = 7'd0;
        wr_commit = 1'b0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].cm);
            check($sformatf("vec %0d pending", i), 32'(commit_pending), 32'(tbl[i].exp_pend));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 7'd0, 1'b0);
    endtask

    // Steps idle until col shows the wanted column (bounded), then checks row.
    task automatic expect_col_row(input string name, input logic [4:0] want_col, input logic [6:0] want_row);
        logic found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1'b0, 3'd0, 7'd0, 1'b0);
            if (col == want_col) found = 1'b1;
        end
        check({name, " col reached"}, 32'(found), 32'd1);
        check({name, " row"}, 32'(row), 32'(want_row));
    endtask

    initial begin
        int   n;
        int   ticks;
        logic done;

        tbl[0]  = '{1'b1, 3'd0, 7'h7C, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 7'h12, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 7'h11, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd3, 7'h12, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd4, 7'h7C, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 7'h00, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 3'd6, 7'h7F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd0, 7'h01, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 7'h02, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd2, 7'h04, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'd3, 7'h08, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 3'd4, 7'h10, 1'b1, 1'b1};

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset portA", 32'(portA), 32'd0);
        check("reset portB", 32'(portB), 32'd0);
        check("reset col", 32'(col), 32'h1F);
        check("reset row", 32'(row), 32'd0);
        check("reset wr_ready", 32'(wr_ready), 32'd0);
        check("reset pending", 32'(commit_pending), 32'd0);
        check("reset frame_tick", 32'(frame_tick), 32'd0);

        reset = 1'b1;
        model_reset();
        idle(45);

        run_vectors(0, 5);
        idle(90);
        expect_col_row("frame A col0", 5'b11110, 7'h7C);

        run_vectors(6, 11);
        idle(90);
        expect_col_row("frame B col0", 5'b11110, 7'h01);

        // Commit on the exact frame-boundary cycle.
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (m_cnt == SD - 1 && m_idx == 4) done = 1'b1;
            else step(1'b0, 3'd0, 7'd0, 1'b0);
        end
        check("boundary reached", 32'(done), 32'd1);
        step(1'b0, 3'd0, 7'd0, 1'b1);
        check("boundary commit pending", 32'(commit_pending), 32'd1);
        n = 0;
        ticks = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(1'b0, 3'd0, 7'd0, i == 9);
            n++;
            if (frame_tick) ticks++;
            if (!commit_pending) done = 1'b1;
        end
        check("boundary swap delay", 32'(n), 32'd40);
        check("boundary tick count", 32'(ticks), 32'd1);
        expect_col_row("swapped back to A col4", 5'b01111, 7'h7C);

        // Write and commit in the same cycle.
        step(1'b1, 3'd2, 7'h7F, 1'b1);
        check("wr+commit pending", 32'(commit_pending), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            step(1'b0, 3'd0, 7'd0, 1'b0);
            if (!commit_pending) done = 1'b1;
        end
        check("wr+commit swap seen", 32'(done), 32'd1);
        expect_col_row("wr+commit col2", 5'b11011, 7'h7F);

        // Reset mid-SHOW with a commit pending.
        step(1'b0, 3'd0, 7'd0, 1'b1);
        check("pre-reset pending", 32'(commit_pending), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (col != 5'b11111) done = 1'b1;
            else step(1'b0, 3'd0, 7'd0, 1'b0);
        end
        check("pre-reset show", 32'(done), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("async reset col", 32'(col), 32'h1F);
        check("async reset row", 32'(row), 32'd0);
        check("async reset pending", 32'(commit_pending), 32'd0);
        check("async reset wr_ready", 32'(wr_ready), 32'd0);
        check("async reset ports", 32'({portA, portB}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held reset col", 32'(col), 32'h1F);
        reset = 1'b1;
        model_reset();
        expect_col_row("post-reset col0 blank", 5'b11110, 7'h00);
        idle(45);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
